// File: rtl/vga_pkg.sv
// vga_pkg: 1080p60 timing constants, derived totals, pixel type and colour-bar palette
package vga_pkg;

    localparam int CNT_W = 12;

    localparam int H_ACTIVE_1080 = 1920;
    localparam int H_FP_1080     = 88;
    localparam int H_SYNC_1080   = 44;
    localparam int H_BP_1080     = 148;
    localparam int V_ACTIVE_1080 = 1080;
    localparam int V_FP_1080     = 4;
    localparam int V_SYNC_1080   = 5;
    localparam int V_BP_1080     = 36;

    localparam int H_TOTAL_1080 = H_ACTIVE_1080 + H_FP_1080 + H_SYNC_1080 + H_BP_1080;
    localparam int V_TOTAL_1080 = V_ACTIVE_1080 + V_FP_1080 + V_SYNC_1080 + V_BP_1080;

    typedef logic [23:0] pixel_t;

    localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
    localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
    localparam pixel_t BAR_CYAN    = 24'h00FFFF;
    localparam pixel_t BAR_GREEN   = 24'h00FF00;
    localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
    localparam pixel_t BAR_RED     = 24'hFF0000;
    localparam pixel_t BAR_BLUE    = 24'h0000FF;
    localparam pixel_t BAR_BLACK   = 24'h000000;

    // Bars run left to right in the classic SMPTE-like order
    function automatic pixel_t bar_color(input logic [2:0] idx);
        return idx == 3'd0 ? BAR_WHITE   :
               idx == 3'd1 ? BAR_YELLOW  :
               idx == 3'd2 ? BAR_CYAN    :
               idx == 3'd3 ? BAR_GREEN   :
               idx == 3'd4 ? BAR_MAGENTA :
               idx == 3'd5 ? BAR_RED     :
               idx == 3'd6 ? BAR_BLUE    : BAR_BLACK;
    endfunction

endpackage

// File: rtl/vga_color_bar.sv
// vga_color_bar: maps a request column to one of 8 equal-width vertical bars, one cycle of latency
module vga_color_bar
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        de,
    input  logic [11:0] x,
    output logic [23:0] rgb
);

    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] idx_full;
    logic [2:0]  idx;

    // A width not divisible by 8 leaves a few trailing pixels; they stay in the last bar
    assign idx_full = x / BAR_W;
    assign idx      = idx_full > 12'd7 ? 3'd7 : idx_full[2:0];

    // Registered colour, black outside the active area or while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= (run && de) ? bar_color(idx) : '0;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1080p60 raster timing with request/output pipeline; VGA_TEST_PATTERN_EN selects colour bars
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_1080,
    parameter int   H_FP     = H_FP_1080,
    parameter int   H_SYNC   = H_SYNC_1080,
    parameter int   H_BP     = H_BP_1080,
    parameter int   V_ACTIVE = V_ACTIVE_1080,
    parameter int   V_FP     = V_FP_1080,
    parameter int   V_SYNC   = V_SYNC_1080,
    parameter int   V_BP     = V_BP_1080,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        en,
    output logic        req_de,
    output logic [11:0] req_x,
    output logic [11:0] req_y,
    input  logic [23:0] rgb_in,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0]  lock_sync;
    logic        lock_s;
    logic        run;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        active_c;
    logic        hs_c;
    logic        vs_c;
    logic        req_hs;
    logic        req_vs;

    assign lock_s   = lock_sync[1];
    assign run      = lock_s & en;
    assign h_wrap   = h_cnt == H_LAST;
    assign v_wrap   = v_cnt == V_LAST;
    assign active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_c     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // Bring the PLL lock into the pixel clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= '0;
        else        lock_sync <= {lock_sync[0], pll_locked};
    end

    // Raster counters; parked at (0,0) whenever stopped so a restart never emits a partial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
        end
    end

    // Request stage: tells the pixel source which pixel to present next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_de <= 1'b0;
            req_x  <= '0;
            req_y  <= '0;
            req_hs <= 1'b0;
            req_vs <= 1'b0;
        end else begin
            req_de <= run && active_c;
            req_x  <= (run && active_c) ? h_cnt : '0;
            req_y  <= (run && active_c) ? v_cnt : '0;
            req_hs <= run && hs_c;
            req_vs <= run && vs_c;
        end
    end

    // Output stage: request stage delayed one cycle, syncs mapped to their configured polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= (run && req_hs) ? HS_POL : ~HS_POL;
            vga_vs      <= (run && req_vs) ? VS_POL : ~VS_POL;
            vga_de      <= run && req_de;
            frame_start <= run && req_de && req_x == 12'd0 && req_y == 12'd0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic unused_rgb_in;
    assign unused_rgb_in = ^rgb_in;

    vga_color_bar #(
        .H_ACTIVE(H_ACTIVE)
    ) u_color_bar (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .de   (req_de),
        .x    (req_x),
        .rgb  (vga_rgb)
    );
`else
    // User pixel captured in the same cycle as its request, blanked outside the active area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vga_rgb <= '0;
        else        vga_rgb <= (run && req_de) ? rgb_in : '0;
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be H_ACTIVE default 1920, active pixels per line.
REQ-002 Parameters SHALL be H_FP 88, H_SYNC 44, H_BP 148, which give a line total of 2200.
REQ-003 Parameters SHALL be V_ACTIVE 1080, V_FP 4, V_SYNC 5, V_BP 36, which give a frame total of 1125.
REQ-004 Parameters SHALL be HS_POL 1 and VS_POL 1; each sets the asserted level of its sync.
REQ-005 Ports SHALL be as follows (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock, 148.5 MHz
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- en  in  1  timing run enable
- req_de  out  1  pixel request
- req_x  out  12  request column
- req_y  out  12  request row
- rgb_in  in  24  user pixel, sampled when req_de=1
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  video data enable
- vga_rgb  out  24  pixel {R,G,B}
- frame_start  out  1  one-cycle pulse

Function
REQ-006 pll_locked SHALL pass through a 2-flop synchronizer; the result is lock_s.
REQ-007 run=lock_s&en; while run=0, h_cnt and v_cnt SHALL hold at 0 and all outputs SHALL hold at their reset values.
REQ-008 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment on each h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-009 Request stage (registered, 1 cycle after counters):
- req_de=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
- req_x=h_cnt and req_y=v_cnt when req_de=1, else 0
REQ-010 Sync timing:
- hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
- vs asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), aligned to line start
REQ-011 Output stage SHALL be the request stage delayed exactly 1 cycle:
- vga_hs, vga_vs, vga_de follow the request stage
- vga_rgb = vga_de ? rgb_in sampled with the matching request : 24'h0
REQ-012 frame_start SHALL pulse for one cycle when vga_de first asserts at pixel (0,0) of each frame.
REQ-013 Sync outputs SHALL drive !HS_POL / !VS_POL when inactive.
REQ-014 If run deasserts mid-frame, both stages SHALL return to reset values within 1 cycle; on the next run=1, counting SHALL restart at (0,0) with no partial line.
REQ-015 Counter arithmetic SHALL be unsigned 12-bit; H_TOTAL and V_TOTAL SHALL each be ≤4096.

Reset
REQ-016 On rst_n=0 the block SHALL reset asynchronously to:
- counters 0 and synchronizer 0
- req_de=0, req_x=0, req_y=0
- vga_de=0, vga_rgb=0, frame_start=0
- vga_hs=!HS_POL, vga_vs=!VS_POL
REQ-017 Reset release SHALL be followed by at least 2 cycles before run can assert, due to the synchronizer.

Configuration
REQ-018 Macro VGA_TEST_PATTERN_EN defined: rgb_in SHALL be ignored, and vga_rgb SHALL be 8 vertical bars each H_ACTIVE/8 wide, in this order:
- white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00
- magenta FF00FF, red FF0000, blue 0000FF, black 000000
REQ-019 Macro undefined: the pass-through of REQ-011 SHALL apply, and no pattern logic SHALL be present.

Structure
REQ-020 Package vga_pkg SHALL hold:
- the 1080p60 timing constants
- the H_TOTAL/V_TOTAL derivations
- the 24-bit pixel typedef
- the bar colour constants
REQ-021 The bar generator SHALL be sub-module vga_color_bar, which maps req_x to a colour and adds 1 cycle of registered latency.

Verification
REQ-022 Reset: assert rst_n=0 with running counters -> vga_hs=0, vga_vs=0, vga_de=0, vga_rgb=0 immediately, without waiting for a clock.
REQ-023 Line timing: en=1, pll_locked=1 ->
- vga_de high for 1920 consecutive cycles per active line
- vga_hs high for 44 cycles starting 88 cycles after vga_de falls
- period 2200 cycles
REQ-024 Frame timing: 1125 lines per frame, and vga_vs high for 5 lines -> frame_start pulses every 2,475,000 cycles.
REQ-025 Lock loss: drop pll_locked at line 500 -> outputs inactive within 3 cycles; on relock, the first vga_de arrives with frame_start at (0,0).
REQ-026 Pass-through (macro off): drive rgb_in = {req_x[7:0], req_y[7:0], 8'hA5} -> vga_rgb at pixel (10,3) = 24'h0A03A5.
REQ-027 Pattern (macro on): vga_rgb SHALL be:
- FFFFFF at pixel x=0
- FFFF00 at x=240
- 000000 at x=1919
- 0 during blanking
